mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One iteration per clock: shift-add for multiplies, restoring
// shift-subtract for divides. Signed operations run on magnitudes and
// apply the sign correction only when the result is written to hi/lo.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for sig_start; mthi/mtlo may write hi/lo
// RUN   | iterating; cnt_q counts completed iterations, 0..WIDTH-1

module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_start,
   input  logic [1:0]       sig_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             sig_mthi,
   input  logic             sig_mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             div_zero_q, div_zero_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   // Operand conditioning at start: magnitudes for signed ops.
   logic             signed_op;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign signed_op = ~sig_op[0];
   assign a_neg     = signed_op & src_a[WIDTH-1];
   assign b_neg     = signed_op & src_b[WIDTH-1];
   assign a_mag     = a_neg ? -src_a : src_a;
   assign b_mag     = b_neg ? -src_b : src_b;

   // Multiply step: acc_lo holds the remaining multiplier bits and
   // collects the low product bits as the partial sum shifts right.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;

   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_hi  = mul_sum[WIDTH:1];
   assign mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

   // Divide step: acc_hi is the partial remainder, acc_lo shifts the
   // dividend out and the quotient bits in. Bit WIDTH of the difference
   // is the borrow, so a clear borrow means the subtract is kept.
   logic [WIDTH:0]   div_shift, div_diff;
   logic             div_ok;
   logic [WIDTH-1:0] div_hi, div_lo;

   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign div_ok    = ~div_diff[WIDTH];
   assign div_hi    = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_lo    = {acc_lo_q[WIDTH-2:0], div_ok};

   logic [WIDTH-1:0] step_hi, step_lo;

   assign step_hi = is_div_q ? div_hi : mul_hi;
   assign step_lo = is_div_q ? div_lo : mul_lo;

   // Sign correction of the final iteration's result. A zero divisor
   // leaves the remainder equal to |a|, which sign-corrects back to a;
   // only the quotient needs forcing to all ones.
   logic [2*WIDTH-1:0] prod_raw, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [WIDTH-1:0]   res_hi, res_lo;

   assign prod_raw = {step_hi, step_lo};
   assign prod_fix = neg_res_q ? -prod_raw : prod_raw;
   assign quo_fix  = div_zero_q ? '1 : (neg_res_q ? -step_lo : step_lo);
   assign rem_fix  = neg_rem_q ? -step_hi : step_hi;
   assign res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
   assign res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

   // Next-state logic for the sequencer, datapath and hi/lo.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      opnd_d     = opnd_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sig_start) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               is_div_d  = sig_op[1];
               neg_res_d = a_neg ^ b_neg;
               acc_hi_d  = '0;
               if (sig_op[1]) begin
                  opnd_d     = b_mag;
                  acc_lo_d   = a_mag;
                  neg_rem_d  = a_neg;
                  div_zero_d = (src_b == '0);
               end else begin
                  opnd_d     = a_mag;
                  acc_lo_d   = b_mag;
                  neg_rem_d  = 1'b0;
                  div_zero_d = 1'b0;
               end
            end else begin
               if (sig_mthi) hi_d = src_a;
               if (sig_mtlo) lo_d = src_a;
            end
         end

         ST_RUN: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               hi_d    = res_hi;
               lo_d    = res_lo;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // All state, with asynchronous clear so reset aborts a run at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         opnd_q     <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         opnd_q     <= opnd_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, random
// operations against an arithmetic reference model, reset abort and
// mthi/mtlo behaviour.

module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         sig_start;
   logic [1:0]   sig_op;
   logic [W-1:0] src_a, src_b;
   logic         sig_mthi, sig_mtlo;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   // Model of the architectural hi/lo contents.
   logic [W-1:0] m_hi, m_lo;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .sig_start (sig_start),
      .sig_op    (sig_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .sig_mthi  (sig_mthi),
      .sig_mtlo  (sig_mtlo),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   // Reference arithmetic straight from the operation definitions.
   function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      q  = 0;
      r  = 0;
      case (op)
         2'b00: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
         default: begin
            if (b == 32'h0) begin
               rl = 32'hFFFF_FFFF;
               rh = a;
            end else if (op == 2'b10) begin
               q  = sa / sb;
               r  = sa % sb;
               rl = q[31:0];
               rh = r[31:0];
            end else begin
               rl = a / b;
               rh = a % b;
            end
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'h0;
         1:       v = 32'h1;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h8000_0000;
         4:       v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic drive_idle();
      sig_start = 1'b0;
      sig_mthi  = 1'b0;
      sig_mtlo  = 1'b0;
      sig_op    = 2'($urandom_range(0, 3));
      src_a     = $urandom;
      src_b     = $urandom;
   endtask

   // Runs one operation from the current negedge and returns at the
   // negedge of the done cycle. disturb_at>0 injects a start plus
   // mthi/mtlo at that RUN cycle; mt_with_start raises mthi/mtlo
   // together with the start itself.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int disturb_at,
                         input bit mt_with_start, input string tag);
      logic [31:0] eh, el;
      model(op, a, b, eh, el);
      sig_start = 1'b1;
      sig_op    = op;
      src_a     = a;
      src_b     = b;
      sig_mthi  = mt_with_start;
      sig_mtlo  = mt_with_start;
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_err++;
            $display("FAIL %s run cycle %0d: busy=%b done=%b hi=%h lo=%h, want busy=1 done=0 hi=%h lo=%h",
                     tag, k, busy, done, hi, lo, m_hi, m_lo);
         end
         drive_idle();
         if (k == disturb_at) begin
            sig_start = 1'b1;
            sig_op    = 2'b01;
            src_a     = 32'h55;
            src_b     = 32'h2;
            sig_mthi  = 1'b1;
            sig_mtlo  = 1'b1;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b1 || hi !== eh || lo !== el) begin
         n_err++;
         $display("FAIL %s result: busy=%b done=%b hi=%h lo=%h, want busy=0 done=1 hi=%h lo=%h",
                  tag, busy, done, hi, lo, eh, el);
      end
      m_hi = eh;
      m_lo = el;
      drive_idle();
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_err++;
            $display("FAIL %s idle %0d: busy=%b done=%b hi=%h lo=%h, want busy=0 done=0 hi=%h lo=%h",
                     tag, k, busy, done, hi, lo, m_hi, m_lo);
         end
         drive_idle();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      m_hi = '0;
      m_lo = '0;
      #2;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
      idle_cycles(2, "post_reset");
   endtask

   task automatic test_directed();
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "multu_max");
      n_cmp++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         n_err++;
         $display("FAIL multu_max const: hi=%h lo=%h, want fffffffe 00000001", hi, lo);
      end
      idle_cycles(1, "multu_max_done_drop");
      run_op(2'b00, 32'hFFFF_FFF9, 32'h3, 0, 1'b0, "mult_neg");
      n_cmp++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
         n_err++;
         $display("FAIL mult_neg const: hi=%h lo=%h, want ffffffff ffffffeb", hi, lo);
      end
      run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 0, 1'b0, "div_neg");
      n_cmp++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         n_err++;
         $display("FAIL div_neg const: hi=%h lo=%h, want ffffffff fffffffd", hi, lo);
      end
      run_op(2'b11, 32'd100, 32'h0, 0, 1'b0, "divu_zero");
      n_cmp++;
      if (hi !== 32'h0000_0064 || lo !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL divu_zero const: hi=%h lo=%h, want 00000064 ffffffff", hi, lo);
      end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_ovf");
      n_cmp++;
      if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL div_ovf const: hi=%h lo=%h, want 00000000 80000000", hi, lo);
      end
      run_op(2'b10, 32'hFFFF_FF9C, 32'h0, 0, 1'b0, "div_zero_neg");
      idle_cycles(2, "directed_tail");
   endtask

   task automatic test_ignore_in_run();
      run_op(2'b11, 32'd10, 32'd3, 5, 1'b0, "ignore_in_run");
      n_cmp++;
      if (hi !== 32'h1 || lo !== 32'h3) begin
         n_err++;
         $display("FAIL ignore_in_run const: hi=%h lo=%h, want 00000001 00000003", hi, lo);
      end
      idle_cycles(3, "ignore_tail");
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] vals [3];
      bit          en_hi [3];
      bit          en_lo [3];
      vals[0] = 32'h1234;      en_hi[0] = 1'b1; en_lo[0] = 1'b0;
      vals[1] = 32'hABCD_0000; en_hi[1] = 1'b0; en_lo[1] = 1'b1;
      vals[2] = 32'h0BAD_F00D; en_hi[2] = 1'b1; en_lo[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sig_mthi = en_hi[i];
         sig_mtlo = en_lo[i];
         src_a    = vals[i];
         if (en_hi[i]) m_hi = vals[i];
         if (en_lo[i]) m_lo = vals[i];
         @(negedge clk);
         n_cmp++;
         if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mt_write %0d: hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=0",
                     i, hi, lo, busy, m_hi, m_lo);
         end
         drive_idle();
      end
      run_op(2'b01, 32'h1234, 32'h10, 0, 1'b1, "start_wins");
      idle_cycles(1, "start_wins_tail");
   endtask

   task automatic test_reset_abort();
      sig_start = 1'b1;
      sig_op    = 2'b01;
      src_a     = 32'hDEAD_BEEF;
      src_b     = 32'h1234_5678;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         drive_idle();
      end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL abort_pre_busy: busy=%b, want 1", busy);
      end
      #2 reset = 1'b1;
      #1;
      m_hi = '0;
      m_lo = '0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_err++;
         $display("FAIL abort_async: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
      idle_cycles(W + 4, "abort_quiet");
      run_op(2'b01, 32'h0001_0003, 32'h0002_0005, 0, 1'b0, "after_abort");
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick_operand();
         b  = pick_operand();
         run_op(op, a, b, 0, 1'b0, $sformatf("rand%0d_op%0d", i, op));
         if ($urandom_range(0, 2) == 0) idle_cycles(1, "rand_gap");
      end
   endtask

   task automatic test_back_to_back();
      run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0, "b2b_div");
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, "b2b_mult");
      run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 0, 1'b0, "b2b_divu");
      idle_cycles(2, "b2b_tail");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_in_run();
      test_mthi_mtlo();
      test_back_to_back();
      test_random();
      test_reset_abort();
      idle_cycles(2, "final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
